// File: rtl/msrh_csr_resp.sv
// Machine-mode CSR file: decodes csr_rd/csr_wr requests, checks privilege/read-only rules, owns mcycle/minstret and trap/MRET state.
// Latency: reads and error flags are combinational; writes, counters, trap and MRET updates land on the next i_clk edge.
// Backpressure: none; every request is answered in the cycle it is presented, illegal ones with resp_error.
module msrh_csr_resp #(
    parameter int                  XLEN_W   = 64,
    parameter logic [XLEN_W-1:0]   MISA_VAL = 64'h8000_0000_0014_1105,
    parameter logic [XLEN_W-1:0]   HART_ID  = '0,
    parameter int                  RETIRE_W = 3
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  logic                i_rd_valid,
    input  logic [11:0]         i_rd_addr,
    output logic [XLEN_W-1:0]   o_rd_data,
    output logic                o_rd_resp_error,
    input  logic                i_wr_valid,
    input  logic [11:0]         i_wr_addr,
    input  logic [XLEN_W-1:0]   i_wr_data,
    output logic                o_wr_resp_error,
    input  logic [1:0]          i_status_priv,
    input  logic [RETIRE_W-1:0] i_retire_cnt,
    input  logic                i_trap_valid,
    input  logic [XLEN_W-1:0]   i_trap_epc,
    input  logic [XLEN_W-1:0]   i_trap_cause,
    input  logic [XLEN_W-1:0]   i_trap_tval,
    input  logic                i_mret_valid,
    output logic [XLEN_W-1:0]   o_mstatus,
    output logic [XLEN_W-1:0]   o_mepc
);

    localparam logic [11:0] A_MSTATUS    = 12'h300;
    localparam logic [11:0] A_MISA       = 12'h301;
    localparam logic [11:0] A_MCOUNTEREN = 12'h306;
    localparam logic [11:0] A_MSCRATCH   = 12'h340;
    localparam logic [11:0] A_MEPC       = 12'h341;
    localparam logic [11:0] A_MCAUSE     = 12'h342;
    localparam logic [11:0] A_MTVAL      = 12'h343;
    localparam logic [11:0] A_MCYCLE     = 12'hB00;
    localparam logic [11:0] A_MINSTRET   = 12'hB02;
    localparam logic [11:0] A_CYCLE      = 12'hC00;
    localparam logic [11:0] A_INSTRET    = 12'hC02;
    localparam logic [11:0] A_MHARTID    = 12'hF14;

    // MIE[3], MPIE[7], MPP[12:11], TVM[20], TSR[22]
    localparam logic [XLEN_W-1:0] MSTATUS_MASK = XLEN_W'(64'h0000_0000_0050_1888);
    localparam int MIE_B  = 3;
    localparam int MPIE_B = 7;

    logic [XLEN_W-1:0] mstatus;
    logic [2:0]        mcounteren;
    logic [XLEN_W-1:0] mscratch;
    logic [XLEN_W-1:0] mepc;
    logic [XLEN_W-1:0] mcause;
    logic [XLEN_W-1:0] mtval;
    logic [XLEN_W-1:0] mcycle;
    logic [XLEN_W-1:0] minstret;

    logic [XLEN_W-1:0] rd_raw;
    logic              rd_illegal;
    logic              wr_illegal;
    logic              wr_ok;
    logic [XLEN_W-1:0] mstatus_nxt;

    // Unimplemented address, insufficient privilege, or a U-mode counter read not enabled by mcounteren.
    function automatic logic csr_illegal(input logic [11:0] addr, input logic [1:0] priv,
                                         input logic [2:0] cnten);
        logic impl;
        logic gate;
        case (addr)
            A_MSTATUS, A_MISA, A_MCOUNTEREN, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL,
            A_MCYCLE, A_MINSTRET, A_CYCLE, A_INSTRET, A_MHARTID: impl = 1'b1;
            default:                                               impl = 1'b0;
        endcase
        gate = (priv == 2'd0) &&
               (((addr == A_CYCLE) && !cnten[0]) || ((addr == A_INSTRET) && !cnten[2]));
        return !impl || (priv < addr[9:8]) || gate;
    endfunction

    // Combinational read mux; errors and idle cycles return zero data.
    always_comb begin
        rd_raw = '0;
        case (i_rd_addr)
            A_MSTATUS:            rd_raw = mstatus;
            A_MISA:               rd_raw = MISA_VAL;
            A_MCOUNTEREN:         rd_raw = XLEN_W'(mcounteren);
            A_MSCRATCH:           rd_raw = mscratch;
            A_MEPC:               rd_raw = mepc;
            A_MCAUSE:             rd_raw = mcause;
            A_MTVAL:              rd_raw = mtval;
            A_MCYCLE, A_CYCLE:    rd_raw = mcycle;
            A_MINSTRET, A_INSTRET: rd_raw = minstret;
            A_MHARTID:            rd_raw = HART_ID;
            default:              rd_raw = '0;
        endcase
        rd_illegal      = csr_illegal(i_rd_addr, i_status_priv, mcounteren);
        o_rd_resp_error = i_rd_valid && rd_illegal;
        o_rd_data       = (i_rd_valid && !rd_illegal) ? rd_raw : '0;
    end

    // Write legality: read rules plus the read-only quadrant addr[11:10]==3.
    always_comb begin
        wr_illegal      = csr_illegal(i_wr_addr, i_status_priv, mcounteren) ||
                          (i_wr_addr[11:10] == 2'b11);
        o_wr_resp_error = i_wr_valid && wr_illegal;
        wr_ok           = i_wr_valid && !wr_illegal;
    end

    // mstatus next value: trap beats MRET beats CSR write, each starting from the current value.
    always_comb begin
        mstatus_nxt = mstatus;
        if (wr_ok && (i_wr_addr == A_MSTATUS)) begin
            mstatus_nxt = i_wr_data & MSTATUS_MASK;
        end
        if (i_mret_valid) begin
            mstatus_nxt          = mstatus;
            mstatus_nxt[MIE_B]   = mstatus[MPIE_B];
            mstatus_nxt[MPIE_B]  = 1'b1;
            mstatus_nxt[12:11]   = 2'b00;
        end
        if (i_trap_valid) begin
            mstatus_nxt          = mstatus;
            mstatus_nxt[MPIE_B]  = mstatus[MIE_B];
            mstatus_nxt[MIE_B]   = 1'b0;
            mstatus_nxt[12:11]   = i_status_priv;
        end
    end

    // Status register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mstatus <= '0;
        end else begin
            mstatus <= mstatus_nxt;
        end
    end

    // Plain CSR writes: mcounteren and mscratch have no other writers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mcounteren <= '0;
            mscratch   <= '0;
        end else if (wr_ok) begin
            if (i_wr_addr == A_MCOUNTEREN) mcounteren <= i_wr_data[2:0];
            if (i_wr_addr == A_MSCRATCH)   mscratch   <= i_wr_data;
        end
    end

    // Trap state: a trap overrides any same-cycle CSR write to these registers; mepc stays halfword aligned.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mepc   <= '0;
            mcause <= '0;
            mtval  <= '0;
        end else if (i_trap_valid) begin
            mepc   <= {i_trap_epc[XLEN_W-1:1], 1'b0};
            mcause <= i_trap_cause;
            mtval  <= i_trap_tval;
        end else if (wr_ok) begin
            if (i_wr_addr == A_MEPC)   mepc   <= {i_wr_data[XLEN_W-1:1], 1'b0};
            if (i_wr_addr == A_MCAUSE) mcause <= i_wr_data;
            if (i_wr_addr == A_MTVAL)  mtval  <= i_wr_data;
        end
    end

    // Free-running counters; a CSR write replaces that cycle's increment.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            if (wr_ok && (i_wr_addr == A_MCYCLE)) mcycle <= i_wr_data;
            else                                   mcycle <= mcycle + 1'b1;
            if (wr_ok && (i_wr_addr == A_MINSTRET)) minstret <= i_wr_data;
            else                                     minstret <= minstret + XLEN_W'(i_retire_cnt);
        end
    end

    assign o_mstatus = mstatus;
    assign o_mepc    = mepc;

endmodule

// File: doc/msrh_csr_resp.md
Name: msrh_csr_resp

Overview:
- Responder end of the CSU CSR read/write interfaces: a machine-mode CSR file serving `csr_rd_if` (combinational read) and `csr_wr_if` (registered write).
- Performs address decode, privilege checks and read-only checks, and returns `resp_error` on illegal accesses.
- Maintains the cycle and instret counters, and accepts trap-entry and MRET updates from the commit stage.
- Drives `mstatus` and `mepc` back to the CSU and the fetch redirect.

Parameters:
- XLEN_W, 64, data width; counters are XLEN_W bits wide.
- MISA_VAL, 64'h8000_0000_0014_1105, constant `misa` read value.
- HART_ID, 0, constant `mhartid` read value.
- RETIRE_W, 3, width of the per-cycle retire count.

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  async active-low reset
- i_rd_valid  in  1  read request
- i_rd_addr  in  12  CSR address
- o_rd_data  out  XLEN_W  read data, same cycle
- o_rd_resp_error  out  1  read illegal, same cycle
- i_wr_valid  in  1  write request
- i_wr_addr  in  12  CSR address
- i_wr_data  in  XLEN_W  write data
- o_wr_resp_error  out  1  write illegal, same cycle
- i_status_priv  in  2  current privilege (U=0, S=1, M=3)
- i_retire_cnt  in  RETIRE_W  instructions retired this cycle
- i_trap_valid  in  1  trap entry
- i_trap_epc  in  XLEN_W  faulting PC
- i_trap_cause  in  XLEN_W  cause
- i_trap_tval  in  XLEN_W  tval
- i_mret_valid  in  1  MRET commit
- o_mstatus  out  XLEN_W  current mstatus
- o_mepc  out  XLEN_W  current mepc

Behaviour:
- Reset (asynchronous): all CSRs are cleared to 0; o_mstatus=0, o_mepc=0.
  - o_rd_data and both resp_error outputs are 0 when their valid is low.
- Implemented CSRs:
  - 0x300 mstatus: writable mask is MIE[3], MPIE[7], MPP[12:11], TVM[20], TSR[22]; all other bits read 0.
  - 0x301 misa: reads MISA_VAL; writes are accepted and ignored, no error.
  - 0x306 mcounteren: bits [2:0] writable.
  - 0x340 mscratch.
  - 0x341 mepc: bit0 is forced to 0 on every update.
  - 0x342 mcause.
  - 0x343 mtval.
  - 0xB00 mcycle.
  - 0xB02 minstret.
  - 0xC00 cycle and 0xC02 instret: read-only aliases of mcycle and minstret.
  - 0xF14 mhartid: reads HART_ID.
- Read errors: `rd_resp_error` = valid & (unimplemented address | i_status_priv < addr[9:8] | U-mode counter gate).
  - Counter gate in U-mode: 0xC00 requires mcounteren[0]; 0xC02 requires mcounteren[2].
  - On error, o_rd_data = 0.
- Write errors: `wr_resp_error` = valid & (any read-error condition on wr_addr | addr[11:10]==2'b11).
  - An erroring write changes no state.
- Read latency is 0 (combinational).
  - A write takes effect at the next posedge.
  - A same-cycle read of the address being written returns the old value (no bypass).
- mcycle: +1 every cycle, wrapping mod 2^XLEN_W.
  - A CSR write to 0xB00 in cycle N loads the written value at edge N; there is no +1 that cycle.
- minstret: += i_retire_cnt every cycle, wrapping.
  - A CSR write to 0xB02 overrides that cycle's increment.
- Trap entry (i_trap_valid), applied at the next edge:
  - mepc <= {epc[XLEN-1:1],0}; mcause <= cause; mtval <= tval.
  - MPIE <= MIE; MIE <= 0; MPP <= i_status_priv.
- MRET (i_mret_valid), applied at the next edge: MIE <= MPIE; MPIE <= 1; MPP <= 0 (U).
- Priority within one cycle: trap > mret > CSR write, evaluated per register.
  - Example: a trap plus a CSR write to mscratch both apply, since they touch different registers.
  - Example: a trap plus a CSR write to mepc → the trap value wins.
- o_mstatus and o_mepc are the registered values; updates are visible the cycle after the edge.
- Reset asserted mid-operation clears everything immediately; the counters restart from 0.

Test Plan:
- Reset, then read 0x300 in M-mode → o_rd_data=0, error=0. Read 0xF14 → HART_ID. Read 0x7C0 → error=1, data=0.
- Write 0x340=0xDEAD_BEEF at cycle N; read 0x340 at cycle N → old 0; read at N+1 → 0xDEAD_BEEF.
- U-mode read 0xC00 with mcounteren=0 → error=1. After M-mode writes mcounteren=1 → U read 0xC00 returns mcycle, no error. U-mode read 0x300 → error=1.
- Write 0xC00 in M-mode → wr_resp_error=1, mcycle unchanged. Write mcycle=0xFFFF_FFFF_FFFF_FFFF → next cycle 0xFFFF…FF, the cycle after that 0 (wrap).
- Trap (epc=0x8000_0103, cause=2, tval=0x13) while MIE=1 in S-mode, with a simultaneous CSR write mepc=0x1234:
  - mepc=0x8000_0102, mcause=2, MIE=0, MPIE=1, MPP=1.
  - Then MRET → MIE=1, MPIE=1, MPP=0.
- i_retire_cnt=3 for 4 cycles, with a write minstret=100 in cycle 2 → final minstret=106.
